// File: rtl/ib_fill_ctrl.sv
// Instruction-buffer fill controller: a two-slot holding buffer between fetch and the IB FIFO,
// with credit-based fetch acceptance and read issue tracking.
module ib_fill_ctrl #(
    parameter int unsigned ENTRY_W = 71,
    parameter int unsigned CAP     = 15
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               flush,
    input  logic               stall,
    input  logic               fetch_valid,
    input  logic [1:0]         fetch_mask,
    input  logic [ENTRY_W-1:0] fetch_data0,
    input  logic [ENTRY_W-1:0] fetch_data1,
    output logic               fetch_ready,
    input  logic               rd_req,
    output logic [ENTRY_W-1:0] fifo_in,
    output logic               fifo_w_en,
    output logic               fifo_r_en,
    output logic               fifo_stall,
    output logic               fifo_flush,
    input  logic               fifo_full,
    output logic               issue_valid,
    output logic [4:0]         ib_count
);

    typedef enum logic [1:0] {
        H0 = 2'd0,
        H1 = 2'd1,
        H2 = 2'd2
    } hold_t;

    localparam logic [6:0] CAP_LIM = 7'(CAP);

    hold_t              state, state_nxt;
    logic [ENTRY_W-1:0] slot0, slot1, slot0_nxt, slot1_nxt;
    logic               wr_fire, rd_fire, accept, hold_drains;
    logic [1:0]         pend;
    logic [6:0]         room_need;

    always_comb begin
        pend        = (state == H2) ? 2'd2 : (state == H1) ? 2'd1 : 2'd0;
        wr_fire     = (state != H0) && !fifo_full && !flush;
        rd_fire     = rd_req && (ib_count != '0) && !stall && !flush;
        hold_drains = (state == H0) || ((state == H1) && wr_fire);
        room_need   = {2'b00, ib_count} + {5'b00000, pend} + 7'd2;
        // Gated by rst_ so the bundle handshake stays closed while reset is held.
        fetch_ready = rst_ && !flush && hold_drains && (room_need <= CAP_LIM);
        accept      = fetch_valid && fetch_ready;
    end

    // Acceptance only happens once the buffer is empty after this cycle's write,
    // so new slots always load from slot0 upward.
    always_comb begin
        state_nxt = state;
        slot0_nxt = slot0;
        slot1_nxt = slot1;
        if (wr_fire) begin
            slot0_nxt = slot1;
            state_nxt = (state == H2) ? H1 : H0;
        end
        if (accept) begin
            case (fetch_mask)
                2'b01: begin
                    slot0_nxt = fetch_data0;
                    state_nxt = H1;
                end
                2'b10: begin
                    slot0_nxt = fetch_data1;
                    state_nxt = H1;
                end
                2'b11: begin
                    slot0_nxt = fetch_data0;
                    slot1_nxt = fetch_data1;
                    state_nxt = H2;
                end
                default: ;
            endcase
        end
        if (flush) begin
            state_nxt = H0;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state       <= H0;
            ib_count    <= '0;
            issue_valid <= 1'b0;
        end else if (flush) begin
            state       <= H0;
            ib_count    <= '0;
            issue_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            ib_count    <= ib_count + 5'(wr_fire) - 5'(rd_fire);
            issue_valid <= rd_fire;
        end
    end

    always_ff @(posedge clk) begin
        slot0 <= slot0_nxt;
        slot1 <= slot1_nxt;
    end

    assign fifo_in    = slot0;
    assign fifo_w_en  = wr_fire;
    assign fifo_r_en  = rd_fire;
    assign fifo_stall = stall;
    assign fifo_flush = flush;

endmodule

// File: tb/tb_ib_fill_ctrl.sv
// Bench for ib_fill_ctrl: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_ib_fill_ctrl;

    localparam int unsigned W   = 71;
    localparam int unsigned CAP = 15;

    logic         clk = 1'b0;
    logic         rst_ = 1'b0;
    logic         flush = 1'b0, stall = 1'b0, fetch_valid = 1'b0, rd_req = 1'b0, fifo_full = 1'b0;
    logic [1:0]   fetch_mask = 2'b00;
    logic [W-1:0] fetch_data0 = '0, fetch_data1 = '0;
    logic         fetch_ready, fifo_w_en, fifo_r_en, fifo_stall, fifo_flush, issue_valid;
    logic [W-1:0] fifo_in;
    logic [4:0]   ib_count;

    int n_cmp = 0;
    int n_bad = 0;

    ib_fill_ctrl #(.ENTRY_W(W), .CAP(CAP)) dut (
        .clk(clk), .rst_(rst_), .flush(flush), .stall(stall),
        .fetch_valid(fetch_valid), .fetch_mask(fetch_mask),
        .fetch_data0(fetch_data0), .fetch_data1(fetch_data1),
        .fetch_ready(fetch_ready), .rd_req(rd_req), .fifo_in(fifo_in),
        .fifo_w_en(fifo_w_en), .fifo_r_en(fifo_r_en), .fifo_stall(fifo_stall),
        .fifo_flush(fifo_flush), .fifo_full(fifo_full),
        .issue_valid(issue_valid), .ib_count(ib_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending slots as a queue, IB occupancy as a plain integer.
    logic [W-1:0] hq[$];
    int           m_cnt = 0;
    logic         m_iv  = 1'b0;

    always @(negedge rst_) begin
        hq.delete();
        m_cnt = 0;
        m_iv  = 1'b0;
    end

    always @(negedge clk) begin
        int   sz;
        logic e_w, e_r, e_rdy;
        if (!rst_) begin
            chk("rst_ready", fetch_ready, 1'b0);
            chk("rst_w_en", fifo_w_en, 1'b0);
            chk("rst_r_en", fifo_r_en, 1'b0);
            chk("rst_count", ib_count, 5'd0);
            chk("rst_iv", issue_valid, 1'b0);
        end else begin
            sz    = hq.size();
            e_w   = (sz > 0) && !fifo_full && !flush;
            e_r   = rd_req && (m_cnt > 0) && !stall && !flush;
            e_rdy = !flush && ((sz == 0) || (sz == 1 && e_w)) && (m_cnt + sz + 2 <= int'(CAP));
            chk("m_ready", fetch_ready, e_rdy);
            chk("m_w_en", fifo_w_en, e_w);
            chk("m_r_en", fifo_r_en, e_r);
            chk("m_count", ib_count, 5'(m_cnt));
            chk("m_iv", issue_valid, m_iv);
            chk("m_fstall", fifo_stall, stall);
            chk("m_fflush", fifo_flush, flush);
            if (e_w) chk("m_fifo_in", fifo_in, hq[0]);
            if (flush) begin
                hq.delete();
                m_cnt = 0;
                m_iv  = 1'b0;
            end else begin
                if (e_w) void'(hq.pop_front());
                if (fetch_valid && e_rdy) begin
                    if (fetch_mask[0]) hq.push_back(fetch_data0);
                    if (fetch_mask[1]) hq.push_back(fetch_data1);
                end
                m_cnt = m_cnt + int'(e_w) - int'(e_r);
                m_iv  = e_r;
            end
        end
    end

    typedef struct {
        logic         fl, st, fv;
        logic [1:0]   m;
        logic [W-1:0] d0, d1;
        logic         rr, ff;
        logic         e_rdy, e_w, e_r;
        logic [W-1:0] e_in;
        logic         e_iv;
        logic [4:0]   e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic fl, st, fv, input logic [1:0] m,
                                input logic [W-1:0] d0, d1, input logic rr, ff,
                                input logic e_rdy, e_w, e_r, input logic [W-1:0] e_in,
                                input logic e_iv, input logic [4:0] e_cnt);
        vec_t v;
        v.fl = fl; v.st = st; v.fv = fv; v.m = m; v.d0 = d0; v.d1 = d1; v.rr = rr; v.ff = ff;
        v.e_rdy = e_rdy; v.e_w = e_w; v.e_r = e_r; v.e_in = e_in; v.e_iv = e_iv; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic step(input logic fl, st, fv, input logic [1:0] m,
                        input logic [W-1:0] d0, d1, input logic rr, ff);
        @(posedge clk);
        #1;
        flush = fl; stall = st; fetch_valid = fv; fetch_mask = m;
        fetch_data0 = d0; fetch_data1 = d1; rd_req = rr; fifo_full = ff;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 2'b00, '0, '0, 0, 0);
    endtask

    task automatic offer(input logic [1:0] m, input logic [W-1:0] d0, d1);
        step(0, 0, 1, m, d0, d1, 0, 0);
        idle(3);
    endtask

    localparam logic [W-1:0] PA = W'(32'hA1);
    localparam logic [W-1:0] PB = W'(32'hB2);
    localparam logic [W-1:0] PC = W'(32'hC3);
    localparam logic [W-1:0] PD = W'(32'hD4);
    localparam logic [W-1:0] PE = W'(32'hE5);
    localparam logic [W-1:0] Z  = '0;

    vec_t tbl[16];

    initial begin
        //              fl st fv m      d0  d1  rr ff  rdy w  r  in  iv cnt
        tbl[0]  = mk(0, 0, 1, 2'b11, PA, PB, 0, 0, 1, 0, 0, Z,  0, 5'd0);
        tbl[1]  = mk(0, 0, 0, 2'b00, Z,  Z,  0, 0, 0, 1, 0, PA, 0, 5'd0);
        tbl[2]  = mk(0, 0, 1, 2'b01, PC, Z,  0, 0, 1, 1, 0, PB, 0, 5'd1);
        tbl[3]  = mk(0, 0, 0, 2'b00, Z,  Z,  0, 0, 1, 1, 0, PC, 0, 5'd2);
        tbl[4]  = mk(0, 0, 0, 2'b00, Z,  Z,  0, 0, 1, 0, 0, Z,  0, 5'd3);
        tbl[5]  = mk(0, 1, 0, 2'b00, Z,  Z,  1, 0, 1, 0, 0, Z,  0, 5'd3);
        tbl[6]  = mk(0, 0, 0, 2'b00, Z,  Z,  1, 0, 1, 0, 1, Z,  0, 5'd3);
        tbl[7]  = mk(0, 0, 1, 2'b10, PE, PD, 0, 0, 1, 0, 0, Z,  1, 5'd2);
        tbl[8]  = mk(0, 0, 0, 2'b00, Z,  Z,  1, 0, 1, 1, 1, PD, 0, 5'd2);
        tbl[9]  = mk(0, 0, 0, 2'b00, Z,  Z,  0, 0, 1, 0, 0, Z,  1, 5'd2);
        tbl[10] = mk(0, 0, 1, 2'b11, PA, PB, 0, 1, 1, 0, 0, Z,  0, 5'd2);
        tbl[11] = mk(0, 0, 0, 2'b00, Z,  Z,  0, 1, 0, 0, 0, Z,  0, 5'd2);
        tbl[12] = mk(0, 0, 0, 2'b00, Z,  Z,  0, 0, 0, 1, 0, PA, 0, 5'd2);
        tbl[13] = mk(1, 0, 1, 2'b11, PC, PD, 1, 0, 0, 0, 0, Z,  0, 5'd3);
        tbl[14] = mk(0, 0, 0, 2'b00, Z,  Z,  0, 0, 1, 0, 0, Z,  0, 5'd0);
        tbl[15] = mk(0, 0, 0, 2'b00, Z,  Z,  1, 0, 1, 0, 0, Z,  0, 5'd0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_count", ib_count, 5'd0);
        chk("reset_ready", fetch_ready, 1'b0);
        @(posedge clk);
        #1 rst_ = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].fl, tbl[i].st, tbl[i].fv, tbl[i].m, tbl[i].d0, tbl[i].d1, tbl[i].rr, tbl[i].ff);
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), fetch_ready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_w_en", i), fifo_w_en, tbl[i].e_w);
            chk($sformatf("tbl%0d_r_en", i), fifo_r_en, tbl[i].e_r);
            if (tbl[i].e_w) chk($sformatf("tbl%0d_fifo_in", i), fifo_in, tbl[i].e_in);
            chk($sformatf("tbl%0d_iv", i), issue_valid, tbl[i].e_iv);
            chk($sformatf("tbl%0d_count", i), ib_count, tbl[i].e_cnt);
        end

        // Credit boundary: 13 entries with an empty holding buffer still admits a bundle, 14 does not.
        step(1, 0, 0, 2'b00, Z, Z, 0, 0);
        idle(1);
        for (int i = 0; i < 6; i++) offer(2'b11, PA, PB);
        offer(2'b01, PC, Z);
        @(negedge clk);
        chk("cap13_count", ib_count, 5'd13);
        chk("cap13_ready", fetch_ready, 1'b1);
        offer(2'b01, PD, Z);
        @(negedge clk);
        chk("cap14_count", ib_count, 5'd14);
        chk("cap14_ready", fetch_ready, 1'b0);
        step(0, 0, 1, 2'b11, PE, PE, 0, 0);
        idle(2);
        @(negedge clk);
        chk("cap14_hold_count", ib_count, 5'd14);

        // Flush with two pending slots, count 7 and a bundle on offer.
        step(1, 0, 0, 2'b00, Z, Z, 0, 0);
        idle(1);
        for (int i = 0; i < 3; i++) offer(2'b11, PA, PB);
        offer(2'b01, PC, Z);
        step(0, 0, 1, 2'b11, PD, PE, 0, 0);
        step(1, 0, 1, 2'b11, PA, PB, 1, 0);
        @(negedge clk);
        chk("flush_count_before", ib_count, 5'd7);
        chk("flush_w_en", fifo_w_en, 1'b0);
        chk("flush_ready", fetch_ready, 1'b0);
        chk("flush_r_en", fifo_r_en, 1'b0);
        idle(1);
        @(negedge clk);
        chk("post_flush_count", ib_count, 5'd0);
        chk("post_flush_w_en", fifo_w_en, 1'b0);
        chk("post_flush_iv", issue_valid, 1'b0);
        idle(1);
        @(negedge clk);
        chk("post_flush2_w_en", fifo_w_en, 1'b0);

        // Asynchronous reset while two slots are pending.
        for (int i = 0; i < 3; i++) offer(2'b11, PA, PB);
        step(0, 0, 1, 2'b11, PC, PD, 1, 0);
        idle(1);
        #2 rst_ = 1'b0;
        #1;
        chk("arst_w_en", fifo_w_en, 1'b0);
        chk("arst_ready", fetch_ready, 1'b0);
        chk("arst_count", ib_count, 5'd0);
        chk("arst_iv", issue_valid, 1'b0);
        @(posedge clk);
        #1 rst_ = 1'b1;
        @(negedge clk);
        chk("arst_after_w_en", fifo_w_en, 1'b0);
        chk("arst_after_ready", fetch_ready, 1'b1);

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 60), 2'($urandom_range(0, 3)),
                 W'({$urandom, $urandom, $urandom}), W'({$urandom, $urandom, $urandom}),
                 ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 5));
        end
        idle(2);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ib_fill_ctrl.md
IB_FILL_CTRL -- requirements
Module: ib_fill_ctrl

Interface
REQ-001 SHALL have parameter ENTRY_W, default 71, giving the IB entry width in bits.
REQ-002 SHALL have parameter CAP, default 15, giving the usable IB FIFO entries.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-004 SHALL have port rst_, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port flush, input, 1 bit: synchronous pipeline flush.
REQ-006 SHALL have port stall, input, 1 bit: decode stall; no read is issued while it is high.
REQ-007 SHALL have port fetch_valid, input, 1 bit: a fetch bundle is offered.
REQ-008 SHALL have port fetch_mask, input, 2 bits: valid slots of the bundle; bit0 is slot0, which is older.
REQ-009 SHALL have ports fetch_data0 and fetch_data1, input, ENTRY_W bits each: the slot payloads.
REQ-010 SHALL have port fetch_ready, output, 1 bit: the bundle is accepted when fetch_valid and fetch_ready are both high.
REQ-011 SHALL have port rd_req, input, 1 bit: decode requests one IB entry.
REQ-012 SHALL have port fifo_in, output, ENTRY_W bits: write data to the IB FIFO.
REQ-013 SHALL have port fifo_w_en, output, 1 bit: write strobe to the IB FIFO.
REQ-014 SHALL have port fifo_r_en, output, 1 bit: read strobe to the IB FIFO.
REQ-015 SHALL have port fifo_stall, output, 1 bit: stall to the IB FIFO, equal to stall.
REQ-016 SHALL have port fifo_flush, output, 1 bit: flush to the IB FIFO, equal to flush.
REQ-017 SHALL have port fifo_full, input, 1 bit: full status from the IB FIFO.
REQ-018 SHALL have port issue_valid, output, 1 bit: the IB FIFO data output holds a fresh entry this cycle.
REQ-019 SHALL have port ib_count, output, 5 bits: the tracked IB occupancy.

Function
REQ-020 SHALL hold accepted slots in a 2-entry holding buffer, with hold state H0, H1 or H2 equal to the number of pending slots.
REQ-021 SHALL compute wr_fire = (state != H0) && !fifo_full && !flush.
REQ-022 SHALL drive fifo_w_en = wr_fire combinationally.
REQ-023 SHALL drive fifo_in from the oldest pending slot.
REQ-024 SHALL compute rd_fire = rd_req && (ib_count != 0) && !stall && !flush.
REQ-025 SHALL drive fifo_r_en = rd_fire.
REQ-026 SHALL never read an entry in the same cycle it is written; that entry is readable from the next cycle.
REQ-027 SHALL update ib_count each cycle as ib_count + wr_fire - rd_fire, so a simultaneous write and read leaves it unchanged.
REQ-028 SHALL never let ib_count exceed CAP or go below 0.
REQ-029 SHALL compute fetch_ready = !flush && holdDrains && (ib_count + pend + 2 <= CAP), where pend is the current hold count and holdDrains = (H0) or (H1 and wr_fire).
REQ-030 SHALL, on acceptance, load the holding buffer so that mask 01 and mask 10 each give 1 pending slot, 11 gives 2 with slot0 written first, and 00 leaves the state unchanged.
REQ-031 SHALL follow these transitions: H2 goes to H1 on wr_fire; H1 goes to H0 on wr_fire with no accept; H1 goes to H1 or H2 on wr_fire with accept; H0 goes to H1 or H2 on accept; any state holds when wr_fire=0 and there is no accept.
REQ-032 SHALL, in H1 with simultaneous wr_fire and acceptance, write the old slot this cycle and the new slot0 on the next cycle.
REQ-033 SHALL hold the current state and slot while fifo_full=1; fifo_full is a safety interlock that credit accounting never triggers in normal operation.
REQ-034 SHALL register issue_valid so that it equals rd_fire of the previous cycle, matching the registered FIFO output.
REQ-035 SHALL, on flush, next cycle set the state to H0, ib_count to 0 and issue_valid to 0, discard pending slots and ignore any bundle offered in that cycle.
REQ-036 SHALL keep fetch_ready, fifo_w_en and fifo_r_en at 0 during a flush cycle.
REQ-037 SHALL give flush priority over every other event in the same cycle.

Reset
REQ-038 SHALL, while rst_=0, immediately clear state to H0, ib_count to 0 and issue_valid to 0, independent of clk.
REQ-039 SHALL hold fifo_w_en, fifo_r_en and fetch_ready at 0 while in reset.
REQ-040 SHALL discard pending slots when reset asserts mid-operation, with no write completing.
REQ-041 SHALL resume normal operation on the first posedge after rst_ deasserts.

Verification
REQ-042 SHALL cover: bundle mask 11 (A,B) offered from reset -> fifo_in=A with fifo_w_en at cycle+1, fifo_in=B at cycle+2, ib_count=2, fetch_ready high at cycle+2.
REQ-043 SHALL cover: bundle mask 10 (payload B) -> one write of fetch_data1, ib_count=1.
REQ-044 SHALL cover: back-to-back bundles, 11 then 01 offered at cycle+2 -> accepted at cycle+2 (H1 drains), writes A,B,C on consecutive cycles.
REQ-045 SHALL cover: fill until ib_count=13 with H0 -> fetch_ready=1; ib_count=14 -> fetch_ready=0; fifo_full never asserts.
REQ-046 SHALL cover: rd_req with ib_count=3 and stall=1 -> fifo_r_en=0, count stays 3; stall=0 -> fifo_r_en=1, issue_valid=1 next cycle, count=2; simultaneous write+read -> count unchanged.
REQ-047 SHALL cover: flush with H2, ib_count=7 and a bundle offered -> next cycle H0, ib_count=0, no writes; rst_ low mid-H2 -> outputs cleared asynchronously.
